// File: rtl/cpu7_exu_lsu_pkg.sv
// cpu7_exu_lsu_pkg: shared types for the cpu7 load/store unit.
//   - LSU operation encodings (LSOC1K_*) and their size/unsigned/store decode
//   - FSM state encodings
//   - access size codes as driven on data_size
package cpu7_exu_lsu_pkg;

   localparam int GRLEN_DEF           = 32;
   localparam int LSOC1K_LSU_CODE_BIT = 3;

   typedef enum logic [LSOC1K_LSU_CODE_BIT-1:0] {
      LSOC1K_LD_B  = 3'd0,
      LSOC1K_LD_H  = 3'd1,
      LSOC1K_LD_W  = 3'd2,
      LSOC1K_LD_BU = 3'd3,
      LSOC1K_LD_HU = 3'd4,
      LSOC1K_ST_B  = 3'd5,
      LSOC1K_ST_H  = 3'd6,
      LSOC1K_ST_W  = 3'd7
   } lsu_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } lsu_state_t;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   function automatic logic [1:0] op_size(lsu_op_t op);
      case (op)
         LSOC1K_LD_B, LSOC1K_LD_BU, LSOC1K_ST_B: op_size = SIZE_B;
         LSOC1K_LD_H, LSOC1K_LD_HU, LSOC1K_ST_H: op_size = SIZE_H;
         default:                                op_size = SIZE_W;
      endcase
   endfunction

   function automatic logic op_unsigned(lsu_op_t op);
      op_unsigned = (op == LSOC1K_LD_BU) || (op == LSOC1K_LD_HU);
   endfunction

   function automatic logic op_store(lsu_op_t op);
      op_store = (op == LSOC1K_ST_B) || (op == LSOC1K_ST_H) || (op == LSOC1K_ST_W);
   endfunction

endpackage

// File: rtl/cpu7_exu_lsu_if.sv
// cpu7_exu_lsu_if: single-outstanding SRAM-like data-memory channel.
//   master : LSU side (drives the request fields, receives addr_ok/data_ok/rdata)
//   slave  : memory side
interface cpu7_exu_lsu_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/cpu7_lsu_align.sv
// cpu7_lsu_align: purely combinational alignment helper for the LSU.
//   st_op/st_addr/st_wdata : E-stage operation being accepted
//     -> issue_addr, wstrb, wdata (request fields), ale (alignment fault)
//   ld_op/ld_lo/ld_rdata   : latched operation, issued address low bits, raw memory data
//     -> ld_data (extracted and sign/zero-extended load result)
// Macro CPU7_LSU_ALE_EN: misaligned half/word accesses fault instead of
// having their low address bits cleared.
module cpu7_lsu_align
   import cpu7_exu_lsu_pkg::*;
(
   input  lsu_op_t     st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_wdata,
   input  lsu_op_t     ld_op,
   input  logic [1:0]  ld_lo,
   input  logic [31:0] ld_rdata,
   output logic [31:0] issue_addr,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        ale,
   output logic [31:0] ld_data
);

   logic [1:0]  st_size;
   logic [31:0] sh;

   always_comb begin
      st_size    = op_size(st_op);
      issue_addr = st_addr;
`ifdef CPU7_LSU_ALE_EN
      ale = ((st_size == SIZE_H) && st_addr[0]) ||
            ((st_size == SIZE_W) && (st_addr[1:0] != 2'b00));
`else
      // Misaligned accesses silently round down to their natural boundary.
      ale = 1'b0;
      if (st_size == SIZE_H)      issue_addr[0]   = 1'b0;
      else if (st_size == SIZE_W) issue_addr[1:0] = 2'b00;
`endif

      case (st_size)
         SIZE_B: begin
            wstrb = 4'b0001 << issue_addr[1:0];
            wdata = {4{st_wdata[7:0]}};
         end
         SIZE_H: begin
            wstrb = 4'b0011 << issue_addr[1:0];
            wdata = {2{st_wdata[15:0]}};
         end
         default: begin
            wstrb = 4'b1111;
            wdata = st_wdata;
         end
      endcase
      if (!op_store(st_op)) wstrb = 4'b0000;
   end

   always_comb begin
      sh = ld_rdata >> {ld_lo, 3'b000};
      case (op_size(ld_op))
         SIZE_B:  ld_data = op_unsigned(ld_op) ? {24'b0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
         SIZE_H:  ld_data = op_unsigned(ld_op) ? {16'b0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/cpu7_exu_lsu.sv
// cpu7_exu_lsu: load/store unit of the cpu7 execute cluster.
//   clk, resetn           : clock, async active-low reset
//   ecl_lsu_*_e           : one memory operation per valid_e pulse from control logic
//   dbus (master)         : single-outstanding data-memory request channel
//   lsu_ecl_*_m           : load result / completion pulse back to control logic
//   lsu_ecl_ale_m/badv_m  : alignment fault flag and faulting address
// Every accepted access ends with exactly one lsu_ecl_rdata_valid_m pulse.
// Macro CPU7_LSU_ALE_EN enables alignment faults; when undefined, misaligned
// addresses are rounded down and ale/badv are tied 0.
module cpu7_exu_lsu
   import cpu7_exu_lsu_pkg::*;
#(
   parameter int GRLEN = GRLEN_DEF
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           ecl_lsu_valid_e,
   input  logic [LSOC1K_LSU_CODE_BIT-1:0] ecl_lsu_op_e,
   input  logic [GRLEN-1:0]               ecl_lsu_base_e,
   input  logic [GRLEN-1:0]               ecl_lsu_offset_e,
   input  logic [GRLEN-1:0]               ecl_lsu_wdata_e,
   input  logic [4:0]                     ecl_lsu_rd_e,
   input  logic                           ecl_lsu_wen_e,
   cpu7_exu_lsu_if.master                 dbus,
   output logic [GRLEN-1:0]               lsu_ecl_rdata_m,
   output logic                           lsu_ecl_rdata_valid_m,
   output logic [4:0]                     lsu_ecl_rd_m,
   output logic                           lsu_ecl_wen_m,
   output logic                           lsu_ecl_ale_m,
   output logic [GRLEN-1:0]               lsu_ecl_badv_m
);

   lsu_state_t  state;
   lsu_op_t     op_e;
   lsu_op_t     op_q;
   logic        wen_q;
   logic [31:0] addr_e;
   logic [31:0] issue_addr;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic        fault;
   logic [31:0] ld_data;
   logic        accept;
   logic        mem_done;

   assign op_e   = lsu_op_t'(ecl_lsu_op_e);
   assign addr_e = ecl_lsu_base_e + ecl_lsu_offset_e;

   // Valid_e in REQ/WAIT is a protocol violation and is dropped here.
   assign accept   = ecl_lsu_valid_e && ((state == S_IDLE) || (state == S_RESP));
   assign mem_done = ((state == S_REQ)  && dbus.data_addr_ok && dbus.data_data_ok) ||
                     ((state == S_WAIT) && dbus.data_data_ok);

   cpu7_lsu_align u_align (
      .st_op      (op_e),
      .st_addr    (addr_e),
      .st_wdata   (ecl_lsu_wdata_e),
      .ld_op      (op_q),
      .ld_lo      (dbus.data_addr[1:0]),
      .ld_rdata   (dbus.data_rdata),
      .issue_addr (issue_addr),
      .wstrb      (st_wstrb),
      .wdata      (st_wdata),
      .ale        (fault),
      .ld_data    (ld_data)
   );

`ifdef CPU7_LSU_ALE_EN
   logic        ale_q;
   logic [31:0] badv_q;
   assign lsu_ecl_ale_m  = ale_q;
   assign lsu_ecl_badv_m = badv_q;
`else
   assign lsu_ecl_ale_m  = 1'b0;
   assign lsu_ecl_badv_m = '0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state                 <= S_IDLE;
         op_q                  <= LSOC1K_LD_B;
         wen_q                 <= 1'b0;
         dbus.data_req         <= 1'b0;
         dbus.data_wr          <= 1'b0;
         dbus.data_size        <= 2'd0;
         dbus.data_addr        <= '0;
         dbus.data_wstrb       <= '0;
         dbus.data_wdata       <= '0;
         lsu_ecl_rdata_m       <= '0;
         lsu_ecl_rdata_valid_m <= 1'b0;
         lsu_ecl_rd_m          <= '0;
         lsu_ecl_wen_m         <= 1'b0;
`ifdef CPU7_LSU_ALE_EN
         ale_q                 <= 1'b0;
         badv_q                <= '0;
`endif
      end else begin
         // Completion flags are single-cycle; only the RESP entry sets them.
         lsu_ecl_rdata_valid_m <= 1'b0;
         lsu_ecl_wen_m         <= 1'b0;
`ifdef CPU7_LSU_ALE_EN
         ale_q                 <= 1'b0;
`endif
         case (state)
            S_IDLE, S_RESP: begin
               state <= S_IDLE;
               if (accept) begin
                  op_q            <= op_e;
                  wen_q           <= ecl_lsu_wen_e;
                  lsu_ecl_rd_m    <= ecl_lsu_rd_e;
                  dbus.data_wr    <= op_store(op_e);
                  dbus.data_size  <= op_size(op_e);
                  dbus.data_addr  <= issue_addr;
                  dbus.data_wstrb <= st_wstrb;
                  dbus.data_wdata <= st_wdata;
`ifdef CPU7_LSU_ALE_EN
                  badv_q          <= fault ? addr_e : 32'b0;
`endif
                  if (fault) begin
                     // Faulted access completes next cycle without touching memory.
                     state                 <= S_RESP;
                     lsu_ecl_rdata_valid_m <= 1'b1;
`ifdef CPU7_LSU_ALE_EN
                     ale_q                 <= 1'b1;
`endif
                  end else begin
                     state         <= S_REQ;
                     dbus.data_req <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (dbus.data_addr_ok) begin
                  dbus.data_req <= 1'b0;
                  if (!dbus.data_data_ok) state <= S_WAIT;
               end
            end
            default: ;  // S_WAIT: addr_ok is don't-care, exit handled by mem_done
         endcase

         if (mem_done) begin
            state                 <= S_RESP;
            lsu_ecl_rdata_m       <= ld_data;
            lsu_ecl_rdata_valid_m <= 1'b1;
            lsu_ecl_wen_m         <= wen_q && !op_store(op_q);
         end
      end
   end

endmodule

// File: tb/tb_cpu7_exu_lsu.sv
module tb_cpu7_exu_lsu;
   import cpu7_exu_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid_e;
   logic [2:0]  op_e;
   logic [31:0] base_e, offset_e, wdata_e;
   logic [4:0]  rd_e;
   logic        wen_e;
   logic [31:0] rdata_m, badv_m;
   logic        valid_m, wen_m, ale_m;
   logic [4:0]  rd_m;

   always #5 clk = ~clk;

   cpu7_exu_lsu_if dbus ();

   cpu7_exu_lsu dut (
      .clk                   (clk),
      .resetn                (resetn),
      .ecl_lsu_valid_e       (valid_e),
      .ecl_lsu_op_e          (op_e),
      .ecl_lsu_base_e        (base_e),
      .ecl_lsu_offset_e      (offset_e),
      .ecl_lsu_wdata_e       (wdata_e),
      .ecl_lsu_rd_e          (rd_e),
      .ecl_lsu_wen_e         (wen_e),
      .dbus                  (dbus.master),
      .lsu_ecl_rdata_m       (rdata_m),
      .lsu_ecl_rdata_valid_m (valid_m),
      .lsu_ecl_rd_m          (rd_m),
      .lsu_ecl_wen_m         (wen_m),
      .lsu_ecl_ale_m         (ale_m),
      .lsu_ecl_badv_m        (badv_m)
   );

   typedef struct {
      lsu_op_t     op;
      logic [31:0] base, off, wdata, rdata;
      logic [4:0]  rd;
      logic        wen;
      int          aok, dok;
      logic [31:0] e_addr;
      logic [1:0]  e_size;
      logic        e_wr;
      logic [3:0]  e_wstrb;
      logic [31:0] e_wdata, e_rdata;
      logic        e_wen;
      logic        fault;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        chk_rdata;
      logic        wen;
      logic [4:0]  rd;
   } exp_t;

   localparam int NV = 12;
   vec_t tv[NV];
   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic vec_t mk(lsu_op_t op, logic [31:0] base, logic [31:0] off,
                               logic [31:0] wdata, logic [31:0] rdata, logic [4:0] rd,
                               logic wen, int aok, int dok, logic [31:0] e_addr,
                               logic [1:0] e_size, logic [3:0] e_wstrb,
                               logic [31:0] e_wdata, logic [31:0] e_rdata, logic e_wen);
      vec_t v;
      v.op = op; v.base = base; v.off = off; v.wdata = wdata; v.rdata = rdata;
      v.rd = rd; v.wen = wen; v.aok = aok; v.dok = dok; v.e_addr = e_addr;
      v.e_size = e_size; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
      v.e_rdata = e_rdata; v.e_wen = e_wen; v.fault = 1'b0;
      v.e_wr = (op == LSOC1K_ST_B) || (op == LSOC1K_ST_H) || (op == LSOC1K_ST_W);
      return v;
   endfunction

   // Scoreboard: every valid_m pulse must match the oldest outstanding access.
   always @(negedge clk) begin
      exp_t e;
      if (valid_m === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid_m", 32'(valid_m), 32'd0);
         end else begin
            e = exp_q.pop_front();
            if (e.chk_rdata) check("rdata_m", rdata_m, e.rdata);
            check("wen_m", 32'(wen_m), 32'(e.wen));
            check("rd_m", 32'(rd_m), 32'(e.rd));
         end
      end
   end

   // Called on a negedge; returns on the following negedge (t1).
   task automatic issue(input int i);
      exp_t e;
      valid_e  = 1'b1;
      op_e     = tv[i].op;
      base_e   = tv[i].base;
      offset_e = tv[i].off;
      wdata_e  = tv[i].wdata;
      rd_e     = tv[i].rd;
      wen_e    = tv[i].wen;
      e.rdata = tv[i].e_rdata; e.chk_rdata = !tv[i].e_wr && !tv[i].fault;
      e.wen = tv[i].e_wen; e.rd = tv[i].rd;
      exp_q.push_back(e);
      @(negedge clk);
      valid_e  = 1'b0;
      base_e   = $urandom; offset_e = $urandom; wdata_e = $urandom;
      rd_e     = 5'($urandom);
   endtask

   // Starts at t1, plays the memory side, ends on the RESP negedge.
   task automatic serve(input int i);
      logic [31:0] a0; logic [3:0] s0; logic [31:0] d0; logic ok;
      if (tv[i].fault) begin
         check("fault_no_req", 32'(dbus.data_req), 32'd0);
         check("fault_valid_m", 32'(valid_m), 32'd1);
         check("ale_m", 32'(ale_m), 32'd1);
         check("badv_m", badv_m, tv[i].e_addr);
         return;
      end
      check("data_req_t1", 32'(dbus.data_req), 32'd1);
      check("data_addr", dbus.data_addr, tv[i].e_addr);
      check("data_size", 32'(dbus.data_size), 32'(tv[i].e_size));
      check("data_wr", 32'(dbus.data_wr), 32'(tv[i].e_wr));
      check("data_wstrb", 32'(dbus.data_wstrb), 32'(tv[i].e_wstrb));
      if (tv[i].e_wr) check("data_wdata", dbus.data_wdata, tv[i].e_wdata);
      a0 = dbus.data_addr; s0 = dbus.data_wstrb; d0 = dbus.data_wdata; ok = 1'b1;
      repeat (tv[i].aok) begin
         dbus.data_rdata = $urandom;
         @(negedge clk);
         if (dbus.data_req !== 1'b1 || dbus.data_addr !== a0 ||
             dbus.data_wstrb !== s0 || dbus.data_wdata !== d0) ok = 1'b0;
      end
      if (tv[i].aok > 0) check("req_stable", 32'(ok), 32'd1);
      dbus.data_addr_ok = 1'b1;
      if (tv[i].dok == 0) begin
         dbus.data_data_ok = 1'b1;
         dbus.data_rdata   = tv[i].rdata;
      end
      @(negedge clk);
      dbus.data_addr_ok = 1'b0;
      dbus.data_data_ok = 1'b0;
      if (tv[i].dok > 0) begin
         check("req_drop", 32'(dbus.data_req), 32'd0);
         // Noise in WAIT: addr_ok and a stray valid_e must both be ignored.
         repeat (tv[i].dok - 1) begin
            dbus.data_addr_ok = 1'b1;
            dbus.data_rdata   = $urandom;
            valid_e = 1'b1; op_e = LSOC1K_ST_W; rd_e = 5'd31; wen_e = 1'b1;
            @(negedge clk);
         end
         dbus.data_addr_ok = 1'b0;
         valid_e           = 1'b0;
         dbus.data_data_ok = 1'b1;
         dbus.data_rdata   = tv[i].rdata;
         @(negedge clk);
         dbus.data_data_ok = 1'b0;
         dbus.data_rdata   = $urandom;
      end
      check("valid_m_latency", 32'(valid_m), 32'd1);
   endtask

   initial begin
      int seen;
      valid_e = 0; op_e = 0; base_e = 0; offset_e = 0; wdata_e = 0; rd_e = 0; wen_e = 0;
      dbus.data_addr_ok = 0; dbus.data_data_ok = 0; dbus.data_rdata = 0;

      tv[0]  = mk(LSOC1K_LD_W,  32'h1000, 32'h4, 0, 32'hDEADBEEF, 5'd5, 1, 0, 1,
                  32'h1004, 2'd2, 4'b0000, 0, 32'hDEADBEEF, 1);
      tv[1]  = mk(LSOC1K_LD_B,  32'h1000, 32'h3, 0, 32'h80123456, 5'd6, 1, 0, 1,
                  32'h1003, 2'd0, 4'b0000, 0, 32'hFFFFFF80, 1);
      tv[2]  = mk(LSOC1K_LD_BU, 32'h1000, 32'h3, 0, 32'h80123456, 5'd7, 1, 1, 1,
                  32'h1003, 2'd0, 4'b0000, 0, 32'h00000080, 1);
      tv[3]  = mk(LSOC1K_ST_H,  32'h2000, 32'h2, 32'hABCD1234, 0, 5'd8, 1, 0, 1,
                  32'h2002, 2'd1, 4'b1100, 32'h12341234, 0, 0);
      tv[4]  = mk(LSOC1K_LD_H,  32'h1000, 32'h2, 0, 32'h80017777, 5'd9, 1, 0, 1,
                  32'h1002, 2'd1, 4'b0000, 0, 32'hFFFF8001, 1);
      tv[5]  = mk(LSOC1K_LD_HU, 32'h1000, 32'h0, 0, 32'h1234F00D, 5'd10, 1, 0, 2,
                  32'h1000, 2'd1, 4'b0000, 0, 32'h0000F00D, 1);
      tv[6]  = mk(LSOC1K_ST_B,  32'h4000, 32'h1, 32'h000000A5, 0, 5'd11, 0, 0, 1,
                  32'h4001, 2'd0, 4'b0010, 32'hA5A5A5A5, 0, 0);
      tv[7]  = mk(LSOC1K_ST_W,  32'hFFFFFFF0, 32'h20, 32'hCAFEF00D, 0, 5'd12, 0, 1, 0,
                  32'h00000010, 2'd2, 4'b1111, 32'hCAFEF00D, 0, 0);
      tv[8]  = mk(LSOC1K_LD_W,  32'h5000, 32'h8, 0, 32'h01020304, 5'd13, 1, 3, 3,
                  32'h5008, 2'd2, 4'b0000, 0, 32'h01020304, 1);
      tv[9]  = mk(LSOC1K_LD_B,  32'h6000, 32'h0, 0, 32'h0000007F, 5'd14, 0, 0, 1,
                  32'h6000, 2'd0, 4'b0000, 0, 32'h0000007F, 0);
      tv[10] = mk(LSOC1K_LD_HU, 32'h7000, 32'h2, 0, 32'hBEEF0000, 5'd15, 1, 0, 0,
                  32'h7002, 2'd1, 4'b0000, 0, 32'h0000BEEF, 1);
`ifdef CPU7_LSU_ALE_EN
      tv[11] = mk(LSOC1K_ST_W,  32'h3000, 32'h1, 32'h55667788, 0, 5'd16, 1, 0, 1,
                  32'h3001, 2'd2, 4'b1111, 32'h55667788, 0, 0);
      tv[11].fault = 1'b1;
`else
      tv[11] = mk(LSOC1K_ST_W,  32'h3000, 32'h1, 32'h55667788, 0, 5'd16, 1, 0, 1,
                  32'h3000, 2'd2, 4'b1111, 32'h55667788, 0, 0);
`endif

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req", 32'(dbus.data_req), 0);
      check("rst_valid_m", 32'(valid_m), 0);
      check("rst_rdata_m", rdata_m, 0);
      check("rst_badv_m", badv_m, 0);
      check("rst_addr", dbus.data_addr, 0);
      check("rst_wen_ale", {30'b0, wen_m, ale_m}, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Table-driven vectors, each followed by a single-pulse check.
      for (int i = 0; i < NV; i++) begin
         issue(i);
         serve(i);
         @(negedge clk);
         check("valid_m_single", 32'(valid_m), 0);
      end

      // Back-to-back: next valid_e arrives in the RESP cycle.
      issue(0);
      serve(0);
      issue(3);
      serve(3);
      @(negedge clk);
      check("b2b_valid_single", 32'(valid_m), 0);

      // Reset while in REQ drops data_req immediately.
      issue(1);
      resetn = 1'b0;
      #1;
      check("rst_req_drop", 32'(dbus.data_req), 0);
      exp_q.delete();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Reset while in WAIT; stale data_ok afterwards must not complete anything.
      issue(0);
      dbus.data_addr_ok = 1'b1;
      @(negedge clk);
      dbus.data_addr_ok = 1'b0;
      resetn = 1'b0;
      #1;
      check("rst_wait_req", 32'(dbus.data_req), 0);
      check("rst_wait_valid", 32'(valid_m), 0);
      exp_q.delete();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      dbus.data_data_ok = 1'b1;
      dbus.data_rdata   = 32'h12345678;
      @(negedge clk);
      dbus.data_data_ok = 1'b0;
      seen = 0;
      repeat (4) begin
         if (valid_m === 1'b1 || dbus.data_req === 1'b1) seen++;
         @(negedge clk);
      end
      check("stale_data_ok_ignored", seen, 0);

      // Recovery after reset.
      issue(4);
      serve(4);
      @(negedge clk);
      repeat (2) @(negedge clk);
      check("sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
